// File: rtl/pdm_cic_decimator.sv
// pdm_cic_decimator: multi-channel PDM-to-PCM CIC decimator, time-multiplexed one channel per cycle.
// Define CIC_ROUND_EN to round and saturate the output instead of truncating it.
module pdm_cic_decimator #(
  parameter int CHANNELS   = 8,
  parameter int STAGES     = 3,
  parameter int DECIMATION = 64,
  parameter int OUT_WIDTH  = 16,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [CHANNELS-1:0]  pdm_data,
  input  logic                 pdm_strobe,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CW-1:0]        out_channel,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 busy,
  output logic                 overrun
);
  localparam int AW = STAGES * $clog2(DECIMATION) + 2;
  localparam int DW = $clog2(DECIMATION);
  localparam int WW = $clog2(CHANNELS + 1);
  localparam int SH = (AW > OUT_WIDTH) ? AW - OUT_WIDTH : 0;
  localparam int EW = AW + OUT_WIDTH + 1;
`ifdef CIC_ROUND_EN
  localparam logic signed [EW-1:0] RND  = (EW'(1) << SH) >> 1;
  localparam logic signed [EW-1:0] MAXV = (EW'(1) << (OUT_WIDTH - 1)) - EW'(1);
`endif
  typedef enum logic [1:0] {IDLE, INTEG, COMB} state_t;
  state_t               state;
  logic [CW-1:0]        ch;
  logic [CHANNELS-1:0]  pdm_reg;
  logic [DW-1:0]        cnt;
  logic                 accept;
  logic [AW-1:0]        integ    [CHANNELS][STAGES];
  logic [AW-1:0]        comb_dly [CHANNELS][STAGES];
  logic [OUT_WIDTH-1:0] frame    [CHANNELS];
  logic [WW-1:0]        wr_ptr;
  logic [CW-1:0]        rd_ptr;
  logic [AW-1:0]        integ_nxt [STAGES];
  logic [AW-1:0]        dly_nxt   [STAGES];
  logic [AW-1:0]        acc;
  logic [AW-1:0]        dif;
  function automatic logic [OUT_WIDTH-1:0] scale(input logic [AW-1:0] v);
    logic signed [EW-1:0] w;
    w = signed'({{(EW - AW){v[AW-1]}}, v});
`ifdef CIC_ROUND_EN
    w = (w + RND) >>> SH;
    return (w > MAXV) ? MAXV[OUT_WIDTH-1:0] : w[OUT_WIDTH-1:0];
`else
    w = w >>> SH;
    return w[OUT_WIDTH-1:0];
`endif
  endfunction
  // Integrator and comb chains for the channel currently selected by ch.
  always_comb begin
    acc = pdm_reg[ch] ? AW'(1) : {AW{1'b1}};
    for (int s = 0; s < STAGES; s++) begin
      acc = integ[ch][s] + acc;
      integ_nxt[s] = acc;
    end
    dif = integ[ch][STAGES-1];
    for (int s = 0; s < STAGES; s++) begin
      dly_nxt[s] = dif;
      dif = dif - comb_dly[ch][s];
    end
  end
  assign out_valid   = wr_ptr > WW'(rd_ptr);
  assign out_channel = rd_ptr;
  assign out_data    = frame[rd_ptr];
  assign busy        = state != IDLE;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      ch      <= '0;
      pdm_reg <= '0;
      cnt     <= '0;
      accept  <= 1'b0;
      overrun <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        frame[c] <= '0;
        for (int s = 0; s < STAGES; s++) begin
          integ[c][s]    <= '0;
          comb_dly[c][s] <= '0;
        end
      end
    end else begin
      if (pdm_strobe && state != IDLE) overrun <= 1'b1;
      // The buffer only recycles once its last entry is consumed, so reads never race a write.
      if (out_valid && out_ready) begin
        if (rd_ptr == CW'(CHANNELS - 1)) begin
          rd_ptr <= '0;
          wr_ptr <= '0;
        end else begin
          rd_ptr <= rd_ptr + 1'b1;
        end
      end
      case (state)
        IDLE: if (pdm_strobe) begin
          pdm_reg <= pdm_data;
          ch      <= '0;
          state   <= INTEG;
        end
        INTEG: begin
          for (int s = 0; s < STAGES; s++) integ[ch][s] <= integ_nxt[s];
          ch <= (ch == CW'(CHANNELS - 1)) ? '0 : ch + 1'b1;
          if (ch == CW'(CHANNELS - 1)) begin
            if (cnt == DW'(DECIMATION - 1)) begin
              cnt    <= '0;
              state  <= COMB;
              accept <= wr_ptr == '0;
              if (wr_ptr != '0) overrun <= 1'b1;
            end else begin
              cnt   <= cnt + 1'b1;
              state <= IDLE;
            end
          end
        end
        COMB: begin
          for (int s = 0; s < STAGES; s++) comb_dly[ch][s] <= dly_nxt[s];
          if (accept) begin
            frame[ch] <= scale(dif);
            wr_ptr    <= wr_ptr + 1'b1;
          end
          ch    <= (ch == CW'(CHANNELS - 1)) ? '0 : ch + 1'b1;
          state <= (ch == CW'(CHANNELS - 1)) ? IDLE : COMB;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pdm_cic_decimator.sv
// tb_pdm_cic_decimator: scoreboard bench for pdm_cic_decimator in its default configuration.
module tb_pdm_cic_decimator;
  localparam int C = 8, AW = 20, OW = 16, R = 64;
  typedef struct packed {logic [2:0] ch; logic [OW-1:0] d;} item_t;
  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [C-1:0]  pdm_data = '0;
  logic          pdm_strobe = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [2:0]    out_channel;
  logic [OW-1:0] out_data;
  logic          busy;
  logic          overrun;
  int            checks = 0;
  int            errors = 0;
  item_t         sb[$];
  item_t         e;
  logic [AW-1:0] mi [C][3];
  logic [AW-1:0] md [C][3];
  int            mcnt, idx, rx_n, settle;
  logic          exp_ovr;
  logic          holding = 1'b0;
  logic [OW-1:0] hold_d;
  logic [2:0]    hold_c;
  pdm_cic_decimator #(.CHANNELS(C), .STAGES(3), .DECIMATION(R), .OUT_WIDTH(OW)) dut (
    .clk(clk), .resetn(resetn), .pdm_data(pdm_data), .pdm_strobe(pdm_strobe),
    .out_valid(out_valid), .out_ready(out_ready), .out_channel(out_channel),
    .out_data(out_data), .busy(busy), .overrun(overrun)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  function automatic logic [C-1:0] pat(input int mode, input int i);
    case (mode)
      0: return 8'hFF;
      1: return 8'h00;
      2: return 8'h08 | {7'd0, (i % 2) == 0};
      default: return 8'($urandom);
    endcase
  endfunction
  function automatic int sval(input int mode, input logic [2:0] c);
    if (mode == 0) return 16384;
    if (mode == 1) return -16384;
    return (c == 3'd0) ? 0 : (c == 3'd3) ? 16384 : -16384;
  endfunction
  task automatic model_reset();
    for (int k = 0; k < C; k++)
      for (int s = 0; s < 3; s++) begin
        mi[k][s] = '0;
        md[k][s] = '0;
      end
    mcnt = 0;
    idx = 0;
    rx_n = 0;
    exp_ovr = 1'b0;
    sb.delete();
  endtask
  task automatic model_strobe(input logic [C-1:0] b);
    logic [AW-1:0] a, y, t;
    logic full;
    for (int k = 0; k < C; k++) begin
      a = b[k] ? AW'(1) : {AW{1'b1}};
      for (int s = 0; s < 3; s++) begin
        mi[k][s] = mi[k][s] + a;
        a = mi[k][s];
      end
    end
    mcnt++;
    if (mcnt == R) begin
      mcnt = 0;
      full = sb.size() != 0;
      if (full) exp_ovr = 1'b1;
      for (int k = 0; k < C; k++) begin
        y = mi[k][2];
        for (int s = 0; s < 3; s++) begin
          t = y - md[k][s];
          md[k][s] = y;
          y = t;
        end
        if (!full) sb.push_back({3'(k), y[AW-1:AW-OW]});
      end
    end
  endtask
  // Called at posedge+1; the strobe is sampled on the next edge and the call returns gap cycles later.
  task automatic drive(input int mode, input int gap, input bit extra);
    logic [C-1:0] b;
    b = pat(mode, idx);
    idx++;
    pdm_data = b;
    pdm_strobe = 1'b1;
    @(posedge clk); #1;
    pdm_strobe = 1'b0;
    pdm_data = 8'($urandom);
    model_strobe(b);
    if (extra) begin
      repeat (2) @(posedge clk);
      #1;
      pdm_strobe = 1'b1;
      @(posedge clk); #1;
      pdm_strobe = 1'b0;
    end
    repeat (gap - 1 - (extra ? 3 : 0)) begin
      @(posedge clk); #1;
    end
  endtask
  task automatic frames(input int n, input int mode, input int gap);
    repeat (n * R) drive(mode, gap, 1'b0);
  endtask
  task automatic wait_drain();
    int t = 0;
    while (sb.size() != 0 && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain", sb.size(), 0);
  endtask
  task automatic do_reset();
    resetn = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_chan"}, out_channel, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ovr"}, overrun, 0);
  endtask
  always @(negedge clk) begin
    if (resetn) begin
      if (holding && out_valid) begin
        chk("hold_data", out_data, hold_d);
        chk("hold_chan", out_channel, hold_c);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("spurious_valid", out_valid, 0);
        else begin
          e = sb.pop_front();
          chk("chan", out_channel, e.ch);
          chk("data", $signed(out_data), $signed(e.d));
          if (settle >= 0 && rx_n / C >= 3) chk("settled", $signed(out_data), sval(settle, out_channel));
          rx_n++;
        end
      end
      holding = out_valid && !out_ready;
      hold_d = out_data;
      hold_c = out_channel;
    end else holding = 1'b0;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end
  initial begin
    settle = -1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    resetn = 1'b1;
    settle = 0;
    frames(5, 0, 40);
    wait_drain();
    chk("ones_rx", rx_n, 40);
    chk("ones_ovr", overrun, 0);
    do_reset();
    settle = 1;
    frames(5, 1, 20);
    wait_drain();
    chk("zeros_rx", rx_n, 40);
    do_reset();
    settle = 2;
    frames(5, 2, 20);
    wait_drain();
    chk("mix_rx", rx_n, 40);
    do_reset();
    settle = -1;
    out_ready = 1'b0;
    frames(1, 3, 20);
    repeat (20) @(posedge clk);
    #1;
    chk("bp_valid", out_valid, 1);
    chk("bp_ovr0", overrun, 0);
    frames(1, 3, 20);
    repeat (20) @(posedge clk);
    #1;
    chk("bp_ovr", overrun, exp_ovr);
    chk("bp_held", sb.size(), 8);
    out_ready = 1'b1;
    wait_drain();
    frames(1, 3, 20);
    wait_drain();
    chk("bp_rx", rx_n, 16);
    do_reset();
    chk("rs_ovr_clr", overrun, 0);
    settle = 0;
    drive(0, 20, 1'b1);
    chk("rs_ovr", overrun, 1);
    repeat (5 * R - 1) drive(0, 20, 1'b0);
    wait_drain();
    chk("rs_rx", rx_n, 40);
    do_reset();
    settle = 2;
    frames(4, 2, 20);
    repeat (R - 1) drive(2, 20, 1'b0);
    drive(2, 1, 1'b0);
    repeat (12) @(posedge clk);
    #1;
    chk("mid_busy", busy, 1);
    resetn = 1'b0;
    #1;
    chk_zero("mid");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    frames(5, 2, 20);
    wait_drain();
    chk("cold_rx", rx_n, 40);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pdm_cic_decimator.md
PDM_CIC_DECIMATOR -- requirements
Module: pdm_cic_decimator

Interface
REQ-001 SHALL have parameter CHANNELS, default 8, number of PDM microphone channels (>=1).
REQ-002 SHALL have parameter STAGES, default 3, number of integrator and comb stages (1..6).
REQ-003 SHALL have parameter DECIMATION, default 64, decimation ratio R (>=2).
REQ-004 SHALL have parameter OUT_WIDTH, default 16, output sample width.
REQ-005 SHALL have port clk, input, 1, single clock for all logic.
REQ-006 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port pdm_data, input, CHANNELS, one PDM bit per channel.
REQ-008 SHALL have port pdm_strobe, input, 1, one-cycle pulse marking a new PDM sample.
REQ-009 SHALL have port out_valid, output, 1, out_data/out_channel hold a sample.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts when out_valid is high.
REQ-011 SHALL have port out_channel, output, $clog2(CHANNELS) (min 1), channel of out_data.
REQ-012 SHALL have port out_data, output, OUT_WIDTH, signed decimated sample.
REQ-013 SHALL have port busy, output, 1, a processing pass is in progress.
REQ-014 SHALL have port overrun, output, 1, sticky error flag.

Function
REQ-015 SHALL define ACC_WIDTH = STAGES*$clog2(DECIMATION)+2; all integrator and comb state uses ACC_WIDTH-bit two's-complement arithmetic with modular wrap-around.
REQ-016 SHALL map PDM bit 1 to +1 and bit 0 to -1.
REQ-017 SHALL use FSM states IDLE, INTEG, COMB: IDLE->INTEG on pdm_strobe; INTEG->COMB after channel CHANNELS-1 when the strobe count reaches DECIMATION, else INTEG->IDLE; COMB->IDLE after channel CHANNELS-1.
REQ-018 SHALL capture pdm_data on the clock edge where pdm_strobe is high in IDLE, and in INTEG process channel k at cycle strobe+1+k through all STAGES integrators in one cycle.
REQ-019 SHALL, in COMB, process channel k at cycle strobe+1+CHANNELS+k through all STAGES combs (differential delay 1), each holding its own per-channel previous value.
REQ-020 SHALL reset the strobe counter to 0 when it reaches DECIMATION, with no cycle lost.
REQ-021 SHALL drive busy high in INTEG and COMB, and low in IDLE.
REQ-022 SHALL ignore a pdm_strobe that arrives while busy and set overrun.
REQ-023 SHALL form out_data as comb output bits [ACC_WIDTH-1 : ACC_WIDTH-OUT_WIDTH], or sign-extend when OUT_WIDTH>=ACC_WIDTH.
REQ-024 SHALL write the comb results for all channels into a CHANNELS-entry output frame buffer, but only if the buffer is empty at COMB entry.
REQ-025 SHALL, if the buffer is not empty at COMB entry, still update the comb state, discard the new frame, and set overrun.
REQ-026 SHALL present buffered samples in channel order 0..CHANNELS-1, with out_valid high while entries remain; an entry advances on out_valid & out_ready.
REQ-027 SHALL keep out_data and out_channel stable while out_valid is high and out_ready is low.
REQ-028 SHALL start out_valid the cycle after the first entry is written, so draining may overlap the COMB pass.

Reset
REQ-029 SHALL, with resetn low, asynchronously clear all integrator and comb state, the strobe counter, the frame buffer and the FSM (to IDLE).
REQ-030 SHALL drive out_valid=0, out_channel=0, out_data=0, busy=0 and overrun=0 during reset.
REQ-031 SHALL abandon any pass in progress when reset is asserted mid-pass, with no partial frame emitted afterwards.
REQ-032 SHALL clear overrun only by reset.

Configuration
REQ-033 SHALL, with CIC_ROUND_EN defined, add 2^(ACC_WIDTH-OUT_WIDTH-1) before truncation (when ACC_WIDTH>OUT_WIDTH) and saturate to +2^(OUT_WIDTH-1)-1 on positive overflow.
REQ-034 SHALL, without CIC_ROUND_EN, use plain truncation per REQ-023.

Verification
REQ-035 SHALL cover: defaults, all channels constant 1, strobe every 40 cycles -> from the 4th output frame onward, every channel's out_data = 16384 (truncation).
REQ-036 SHALL cover: all channels constant 0 -> settled out_data = -16384 on every channel, in channel order 0..7.
REQ-037 SHALL cover: channel 0 alternating 1/0 per strobe, channel 3 constant 1, others constant 0 -> settled values ch0=0, ch3=16384, others -16384.
REQ-038 SHALL cover: out_ready held low across two frame boundaries -> first frame held intact, second discarded, overrun=1, and the third frame is correct after draining.
REQ-039 SHALL cover: pdm_strobe repeated 3 cycles after a strobe -> strobe ignored, overrun=1, and the processed-strobe count is unchanged.
REQ-040 SHALL cover: resetn pulsed low during COMB at channel 4 -> all outputs 0 immediately, no out_valid until a fresh full frame, and outputs identical to a cold start.
